// File: rtl/dieu_khien_bom_pkg.sv
// Shared types and helpers for the tank-fill pump controller (dieu_khien_bom).
package dieu_khien_bom_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD_OFF = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    // Bits needed to hold any count from 0 up to max_val inclusive.
    function automatic int unsigned timer_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dieu_khien_bom_loc_nhieu.sv
// Level-sensor debouncer: output follows the raw input only after it has
// differed for DEB_CYCLES consecutive cycles. Resets to 1 ("water present").
module loc_nhieu
    import dieu_khien_bom_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o
);

    localparam int unsigned CW = timer_width(DEB_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b1;
        end else if (raw_i == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            cnt_q <= '0;
            db_q  <= raw_i;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/dieu_khien_bom.sv
// Pump-pair fill sequencer: hysteresis, lead alternation, anti-short-cycling,
// drive pulse train and fault latch. Optional assist pump: DIEU_KHIEN_BOM_ASSIST_EN.
module dieu_khien_bom
    import dieu_khien_bom_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned MIN_RUN       = 1000,
    parameter int unsigned MIN_OFF       = 1000,
    parameter int unsigned PULSE_HALF    = 500,
    parameter int unsigned MAX_RUN       = 100000,
    parameter int unsigned ASSIST_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       high,
    input  logic       low,
    input  logic       fault_clr,
    output logic [1:0] pump_on,
    output logic       pump_clk,
    output logic       lead,
    output logic       fault,
    output logic [1:0] state
);

    localparam int unsigned TW = timer_width(MAX_RUN > MIN_OFF ? MAX_RUN : MIN_OFF);
    localparam int unsigned PW = timer_width(PULSE_HALF);

    if (MAX_RUN <= MIN_RUN) begin : g_bad_max_run
        $error("dieu_khien_bom: MAX_RUN must exceed MIN_RUN");
    end
    if (ASSIST_CYCLES == 0) begin : g_bad_assist
        $error("dieu_khien_bom: ASSIST_CYCLES must be at least 1");
    end

    logic high_db;
    logic low_db;

    loc_nhieu #(.DEB_CYCLES(DEB_CYCLES)) u_loc_high (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (high),
        .db_o  (high_db)
    );

    loc_nhieu #(.DEB_CYCLES(DEB_CYCLES)) u_loc_low (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (low),
        .db_o  (low_db)
    );

    logic empty_c;
    logic full_c;
    logic bad_c;

    assign empty_c = !high_db && !low_db;
    assign full_c  =  high_db &&  low_db;
    assign bad_c   =  high_db && !low_db;

    state_e        state_q,    state_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [PW-1:0] pulse_q,    pulse_d;
    logic [1:0]    pump_on_q,  pump_on_d;
    logic          pump_clk_q, pump_clk_d;
    logic          lead_q,     lead_d;
    logic          fault_q,    fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            timer_q    <= '0;
            pulse_q    <= '0;
            pump_on_q  <= '0;
            pump_clk_q <= 1'b0;
            lead_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pulse_q    <= pulse_d;
            pump_on_q  <= pump_on_d;
            pump_clk_q <= pump_clk_d;
            lead_q     <= lead_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        pulse_d    = '0;
        pump_clk_d = 1'b0;
        pump_on_d  = '0;

        case (state_q)
            ST_OFF: begin
                if (bad_c)                state_d = ST_FAULT;
                else if (en && empty_c)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bad_c)                                state_d = ST_FAULT;
                else if (timer_q == TW'(MAX_RUN - 1))     state_d = ST_FAULT;
                else if (!en)                             state_d = ST_HOLD_OFF;
                else if (full_c && timer_q >= TW'(MIN_RUN - 1))
                                                          state_d = ST_HOLD_OFF;
            end
            ST_HOLD_OFF: begin
                if (bad_c)                                state_d = ST_FAULT;
                else if (timer_q == TW'(MIN_OFF - 1))     state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (fault_clr && !bad_c)                  state_d = ST_HOLD_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        if (state_d == state_q && (state_q == ST_RUN || state_q == ST_HOLD_OFF)) begin
            timer_d = timer_q + TW'(1);
        end

        // Lead swaps only after a completed or aborted fill, never on a fault.
        lead_d = lead_q ^ (state_q == ST_RUN && state_d == ST_HOLD_OFF);

        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (pulse_q == PW'(PULSE_HALF - 1)) begin
                pump_clk_d = !pump_clk_q;
            end else begin
                pulse_d    = pulse_q + PW'(1);
                pump_clk_d = pump_clk_q;
            end
        end

        if (state_d == ST_RUN) begin
            pump_on_d[lead_q] = 1'b1;
`ifdef DIEU_KHIEN_BOM_ASSIST_EN
            if (32'(timer_d) >= ASSIST_CYCLES - 1) begin
                pump_on_d[!lead_q] = 1'b1;
            end
`endif
        end

        fault_d = (state_d == ST_FAULT);
    end

    assign pump_on  = pump_on_q;
    assign pump_clk = pump_clk_q;
    assign lead     = lead_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_dieu_khien_bom.sv
// Bench for dieu_khien_bom: directed scenarios plus random sensor activity,
// every cycle compared with a spec-level reference model.
module tb_dieu_khien_bom;

    localparam int DEB    = 4;
    localparam int MINRUN = 20;
    localparam int MINOFF = 10;
    localparam int PH     = 3;
    localparam int MAXRUN = 200;
    localparam int ASSIST = 50;

    localparam int S_OFF = 0, S_RUN = 1, S_HOLD = 2, S_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       high = 1'b1;
    logic       low = 1'b1;
    logic       fault_clr = 1'b0;
    logic [1:0] pump_on;
    logic       pump_clk;
    logic       lead;
    logic       fault;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    dieu_khien_bom #(
        .DEB_CYCLES    (DEB),
        .MIN_RUN       (MINRUN),
        .MIN_OFF       (MINOFF),
        .PULSE_HALF    (PH),
        .MAX_RUN       (MAXRUN),
        .ASSIST_CYCLES (ASSIST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .high      (high),
        .low       (low),
        .fault_clr (fault_clr),
        .pump_on   (pump_on),
        .pump_clk  (pump_clk),
        .lead      (lead),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: sensor filters, state, cycles spent in state, lead pump.
    int m_st, m_tmr, m_lead, m_hdb, m_ldb, m_hcnt, m_lcnt;

    task automatic model_reset();
        m_st = S_OFF; m_tmr = 0; m_lead = 0;
        m_hdb = 1; m_ldb = 1; m_hcnt = 0; m_lcnt = 0;
    endtask

    task automatic model_step();
        bit empty, full, bad;
        int nst;
        empty = (m_hdb == 0) && (m_ldb == 0);
        full  = (m_hdb == 1) && (m_ldb == 1);
        bad   = (m_hdb == 1) && (m_ldb == 0);
        nst = m_st;
        case (m_st)
            S_OFF:   if (bad) nst = S_FAULT; else if (en && empty) nst = S_RUN;
            S_RUN:   if (bad || m_tmr == MAXRUN - 1) nst = S_FAULT;
                     else if (!en) nst = S_HOLD;
                     else if (full && m_tmr >= MINRUN - 1) nst = S_HOLD;
            S_HOLD:  if (bad) nst = S_FAULT; else if (m_tmr == MINOFF - 1) nst = S_OFF;
            default: if (fault_clr && !bad) nst = S_HOLD;
        endcase
        if (m_st == S_RUN && nst == S_HOLD) m_lead = 1 - m_lead;
        m_tmr = (nst == m_st) ? m_tmr + 1 : 0;
        m_st  = nst;
        if (int'(high) == m_hdb) m_hcnt = 0;
        else begin
            m_hcnt++;
            if (m_hcnt == DEB) begin m_hdb = int'(high); m_hcnt = 0; end
        end
        if (int'(low) == m_ldb) m_lcnt = 0;
        else begin
            m_lcnt++;
            if (m_lcnt == DEB) begin m_ldb = int'(low); m_lcnt = 0; end
        end
    endtask

    function automatic int exp_pump_on();
        int v = 0;
        if (m_st == S_RUN) begin
            v = 1 << m_lead;
`ifdef DIEU_KHIEN_BOM_ASSIST_EN
            if (m_tmr >= ASSIST - 1) v = v | (1 << (1 - m_lead));
`endif
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state",    32'(state),    m_st);
        check("pump_on",  32'(pump_on),  exp_pump_on());
        check("pump_clk", 32'(pump_clk), (m_st == S_RUN) ? (m_tmr / PH) % 2 : 0);
        check("lead",     32'(lead),     m_lead);
        check("fault",    32'(fault),    (m_st == S_FAULT) ? 1 : 0);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic wait_state(input int target, input int budget);
        int n = 0;
        while (int'(state) != target && n < budget) begin
            step(1);
            n++;
        end
        check("wait_state", 32'(state), target);
    endtask

    initial begin
        int n;
        int r;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check("rst_state",    32'(state),    S_OFF);
        check("rst_pump_on",  32'(pump_on),  0);
        check("rst_pump_clk", 32'(pump_clk), 0);
        check("rst_lead",     32'(lead),     0);
        check("rst_fault",    32'(fault),    0);
        rst_n = 1'b1;
        step(2);

        // Empty tank start: debounce then RUN on lead 0.
        high = 1'b0; low = 1'b0; en = 1'b1;
        step(DEB);
        check("start_not_yet", 32'(state), S_OFF);
        step(1);
        check("start_pump_on", 32'(pump_on), 2'b01);
        step(10);

        // Fill with hysteresis: stops only when full and MIN_RUN satisfied.
        low = 1'b1;
        step($urandom_range(3, 8));
        high = 1'b1;
        wait_state(S_HOLD, 40);
        check("fill_lead", 32'(lead), 1);
        check("fill_pump_off", 32'(pump_on), 0);
        wait_state(S_OFF, 20);
        high = 1'b0; low = 1'b0;
        wait_state(S_RUN, 20);
        check("second_pump", 32'(pump_on), 2'b10);

        // Fill again, then glitch test in OFF with en low.
        high = 1'b1; low = 1'b1;
        wait_state(S_HOLD, 60);
        en = 1'b0; high = 1'b0; low = 1'b0;
        wait_state(S_OFF, 20);
        step(DEB + 2);
        low = 1'b1;
        step(2);
        low = 1'b0;
        step(6);
        check("glitch_state", 32'(state), S_OFF);

        // Inconsistent sensors in RUN latch a fault; clear only once fixed.
        en = 1'b1;
        step(1);
        check("glitch_run", 32'(state), S_RUN);
        step(3);
        high = 1'b1;
        step(DEB + 1);
        check("bad_state", 32'(state), S_FAULT);
        check("bad_fault", 32'(fault), 1);
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        check("clr_ignored", 32'(state), S_FAULT);
        high = 1'b0;
        step(DEB);
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        check("clr_ok", 32'(state), S_HOLD);
        check("clr_fault", 32'(fault), 0);

        // Dry run: MAX_RUN run cycles then fault, lead unchanged.
        wait_state(S_RUN, 30);
        n = 1;
        while (int'(state) == S_RUN && n < MAXRUN + 50) begin
            step(1);
            if (int'(state) == S_RUN) n++;
            if (n == ASSIST && int'(state) == S_RUN)
`ifdef DIEU_KHIEN_BOM_ASSIST_EN
                check("assist_join", 32'(pump_on), 2'b11);
`else
                check("assist_join", 32'(pump_on), 2'b01);
`endif
        end
        check("dry_run_len", n, MAXRUN);
        check("dry_state", 32'(state), S_FAULT);
        check("dry_lead", 32'(lead), 0);

        // en drop mid-run aborts immediately and swaps lead.
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        wait_state(S_RUN, 30);
        step(5);
        en = 1'b0;
        step(1);
        check("en_drop_state", 32'(state), S_HOLD);
        check("en_drop_lead", 32'(lead), 1);
        wait_state(S_OFF, 20);

        // Random sensor activity, including short glitches and faults.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 7);
            if (r < 3)      begin high = 1'b0; low = 1'b0; end
            else if (r < 5) begin high = 1'b0; low = 1'b1; end
            else if (r < 7) begin high = 1'b1; low = 1'b1; end
            else            begin high = 1'b1; low = 1'b0; end
            en = ($urandom_range(0, 9) != 0);
            fault_clr = ($urandom_range(0, 3) == 0);
            step(1);
            fault_clr = 1'b0;
            step($urandom_range(1, 30));
        end

        // Asynchronous reset while running.
        high = 1'b0; low = 1'b0; en = 1'b1;
        step(DEB + 1);
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        wait_state(S_RUN, 80);
        step(7);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_pump_on", 32'(pump_on), 0);
        check("arst_state",   32'(state),   S_OFF);
        check("arst_clk",     32'(pump_clk), 0);
        check("arst_lead",    32'(lead),    0);
        #2 rst_n = 1'b1;
        step(DEB + 1);
        check("arst_restart", 32'(state), S_RUN);
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
